// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle control FSM: the state
// enumeration, the opcodes the controller understands, and the ALU operation codes.
package mc_ctrl_pkg;

    localparam int ST_W  = 4;
    localparam int OPC_W = 6;

    typedef enum logic [ST_W-1:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    // Instruction opcodes (bits 31:26)
    localparam logic [OPC_W-1:0] RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] LW    = 6'b100011;
    localparam logic [OPC_W-1:0] SW    = 6'b101011;
    localparam logic [OPC_W-1:0] BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] J     = 6'b000010;
    localparam logic [OPC_W-1:0] ADDI  = 6'b001000;

    // ALU operation codes
    localparam logic [OPC_W-1:0] NOP   = 6'b000000;
    localparam logic [OPC_W-1:0] ADD   = 6'b100000;
    localparam logic [OPC_W-1:0] SUB   = 6'b100010;

    // True for every opcode the controller can sequence
    function automatic logic op_legal(input logic [OPC_W-1:0] op);
        return (op == RTYPE) || (op == LW) || (op == SW) ||
               (op == BEQ)   || (op == J)  || (op == ADDI);
    endfunction

endpackage

// File: rtl/mc_control_fsm_aluop_dec.sv
// ALU operation selection: a pure decode of the current control state,
// with the R-type funct field passed straight through during execute.
module mc_aluop_dec
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  state_t          state,
    input  logic [OP_W-1:0] funct,
    output logic [OP_W-1:0] alu_op
);

    // Address/PC arithmetic adds, compare subtracts, R-type uses funct
    always_comb begin
        alu_op = OP_W'(NOP);
        case (state)
            FETCH,
            DECODE,
            MEM_ADDR,
            ADDI_EXEC: alu_op = OP_W'(ADD);
            BRANCH:    alu_op = OP_W'(SUB);
            R_EXEC:    alu_op = funct;
            default:   alu_op = OP_W'(NOP);
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle datapath controller. Moore outputs decoded from the state
// register; the only input-dependent outputs are the FETCH write enables
// (gated by memory ready), illegal_op in DECODE and the funct pass-through.
// Build option: MC_MEM_WAIT_EN -- when defined, FETCH/MEM_RD/MEM_WR stall
// while mem_ready=0; when undefined mem_ready is ignored and treated as 1.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int STATE_W = 4,   // must be at least ST_W
    parameter int OP_W    = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            i_or_d,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_source,
    output logic [OP_W-1:0] alu_op,
    output logic            illegal_op
);

    logic [STATE_W-1:0] r_state;
    state_t             w_state;
    state_t             w_next;
    logic               w_ready;
    logic               w_unused_in;

    // The branch decision (zero AND pc_write_cond) lives in the datapath,
    // so zero is only routed here for interface completeness.
`ifdef MC_MEM_WAIT_EN
    assign w_ready     = mem_ready;
    assign w_unused_in = zero;
`else
    assign w_ready     = 1'b1;
    assign w_unused_in = zero ^ mem_ready;
`endif

    assign w_state = state_t'(r_state[ST_W-1:0]);

    // State register; reset wins over any in-flight memory access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= STATE_W'(FETCH);
        end else begin
            r_state <= STATE_W'(w_next);
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        w_next        = w_state;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        case (w_state)
            FETCH: begin
                // PC+4 and IR load commit only once the word is back
                mem_read  = 1'b1;
                ir_write  = w_ready;
                pc_write  = w_ready;
                alu_src_b = 2'd1;
                if (w_ready) w_next = DECODE;
            end
            DECODE: begin
                // Speculative branch target computed while decoding
                alu_src_b = 2'd3;
                case (opcode)
                    LW, SW:  w_next = MEM_ADDR;
                    RTYPE:   w_next = R_EXEC;
                    BEQ:     w_next = BRANCH;
                    J:       w_next = JUMP;
                    ADDI:    w_next = ADDI_EXEC;
                    default: begin
                        w_next     = FETCH;
                        illegal_op = rst_n;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                w_next    = (opcode == SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (w_ready) w_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = FETCH;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (w_ready) w_next = FETCH;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd0;
                w_next    = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                w_next    = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'd0;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                w_next        = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                w_next    = FETCH;
            end
            ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                w_next    = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write = 1'b1;
                w_next    = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    mc_aluop_dec #(
        .OP_W   (OP_W)
    ) u_aluop_dec (
        .state  (w_state),
        .funct  (funct),
        .alu_op (alu_op)
    );

endmodule
